// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared constants, enums and helpers for the bomberman video blocks
// Purpose: screen geometry, renderer sprite indices, player FSM states,
//          direction encoding and a signed clamp helper.
// Ports:   none (package).
package bomberman_pkg;

  localparam int HACTIVE     = 800;
  localparam int VACTIVE     = 600;
  localparam int SPRITE_SIZE = 32;

  localparam logic [2:0] SPR_DOWN   = 3'd0;
  localparam logic [2:0] SPR_UP     = 3'd1;
  localparam logic [2:0] SPR_LEFT   = 3'd2;
  localparam logic [2:0] SPR_RIGHT  = 3'd3;
  localparam logic [2:0] SPR_DEATH0 = 3'd4;
  localparam logic [2:0] SPR_DEATH1 = 3'd5;
  localparam logic [2:0] SPR_DEATH2 = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DYING, ST_DEAD} player_state_t;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // Sum is carried one bit wider than a coordinate so the clamp sees the
  // true value before it is narrowed back to 11 bits.
  function automatic logic signed [10:0] clamp11(input logic signed [11:0] v,
                                                 input logic signed [11:0] lo,
                                                 input logic signed [11:0] hi);
    if (v < lo) return lo[10:0];
    if (v > hi) return hi[10:0];
    return v[10:0];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - frame tick counter with clear and terminal-count pulse
// Purpose: counts tick pulses modulo N; expired pulses on the N-th tick.
// Ports:   clk, reset (async, active-high), clear (restart count at 0,
//          wins over tick), tick (count enable), expired (terminal count).
module frame_timer #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] count;

  assign expired = tick && !clear && (count == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= expired ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - per-player motion and death-animation controller
// Purpose: once per frame turns the button state into a clamped candidate
//          position, asks the map block for permission, commits accepted
//          moves and sequences the death sprites after a hit.
// Ports:   clk, reset (async, active-high); frame_tick, btn {up,down,left,right},
//          hit, restart in; move_req/candX/candY out, move_ack/move_ok in;
//          centerX1/centerY1/sprite_num/alive out to the renderer. All outputs registered.
module player_ctrl import bomberman_pkg::*; #(
  parameter int STEP         = 2,
  parameter int START_X      = 64,
  parameter int START_Y      = 64,
  parameter int XMIN         = 0,
  parameter int YMIN         = 0,
  parameter int XMAX         = HACTIVE - SPRITE_SIZE,
  parameter int YMAX         = VACTIVE - SPRITE_SIZE,
  parameter int DEATH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         btn,
  input  logic               hit,
  input  logic               restart,
  output logic               move_req,
  output logic signed [10:0] candX,
  output logic signed [10:0] candY,
  input  logic               move_ack,
  input  logic               move_ok,
  output logic signed [10:0] centerX1,
  output logic signed [10:0] centerY1,
  output logic [2:0]         sprite_num,
  output logic               alive
);

  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] XMIN_S  = 12'(XMIN);
  localparam logic signed [11:0] YMIN_S  = 12'(YMIN);
  localparam logic signed [11:0] XMAX_S  = 12'(XMAX);
  localparam logic signed [11:0] YMAX_S  = 12'(YMAX);
  localparam logic signed [10:0] START_XS = 11'(START_X);
  localparam logic signed [10:0] START_YS = 11'(START_Y);

  player_state_t     state, state_n;
  logic              req_n, alive_n;
  logic signed [10:0] cx_n, cy_n, px_n, py_n;
  logic [2:0]        spr_n;

  dir_t              dir;
  logic [2:0]        face;
  logic signed [11:0] dx, dy;
  logic signed [10:0] tx, ty;

  logic              timer_clear, timer_expired;

  frame_timer #(.N(DEATH_FRAMES)) u_death_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (frame_tick && (state == ST_DYING)),
    .expired (timer_expired)
  );

  // Button priority: up > down > left > right.
  always_comb begin
    dir = DIR_RIGHT;
    if (btn[3])      dir = DIR_UP;
    else if (btn[2]) dir = DIR_DOWN;
    else if (btn[1]) dir = DIR_LEFT;
  end

  always_comb begin
    dx   = '0;
    dy   = '0;
    face = SPR_RIGHT;
    case (dir)
      DIR_UP:    begin dy = -STEP_S; face = SPR_UP;    end
      DIR_DOWN:  begin dy =  STEP_S; face = SPR_DOWN;  end
      DIR_LEFT:  begin dx = -STEP_S; face = SPR_LEFT;  end
      default:   begin dx =  STEP_S; face = SPR_RIGHT; end
    endcase
    tx = clamp11({centerX1[10], centerX1} + dx, XMIN_S, XMAX_S);
    ty = clamp11({centerY1[10], centerY1} + dy, YMIN_S, YMAX_S);
  end

  always_comb begin
    state_n     = state;
    req_n       = move_req;
    cx_n        = candX;
    cy_n        = candY;
    px_n        = centerX1;
    py_n        = centerY1;
    spr_n       = sprite_num;
    alive_n     = alive;
    timer_clear = 1'b0;

    if (hit && (state == ST_IDLE || state == ST_CHECK)) begin
      // A hit abandons any outstanding request, even one acked this cycle.
      state_n     = ST_DYING;
      req_n       = 1'b0;
      alive_n     = 1'b0;
      spr_n       = SPR_DEATH0;
      timer_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick && (btn != 4'b0000)) begin
            spr_n = face;
            if (tx != centerX1 || ty != centerY1) begin
              cx_n    = tx;
              cy_n    = ty;
              req_n   = 1'b1;
              state_n = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (move_ack) begin
            if (move_ok) begin
              px_n = candX;
              py_n = candY;
            end
            req_n   = 1'b0;
            state_n = ST_IDLE;
          end
        end
        ST_DYING: begin
          if (timer_expired) begin
            if (sprite_num == SPR_DEATH2) state_n = ST_DEAD;
            else                          spr_n   = sprite_num + 3'd1;
          end
        end
        default: begin
          if (restart) begin
            px_n    = START_XS;
            py_n    = START_YS;
            cx_n    = START_XS;
            cy_n    = START_YS;
            spr_n   = SPR_DOWN;
            alive_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      move_req   <= 1'b0;
      candX      <= START_XS;
      candY      <= START_YS;
      centerX1   <= START_XS;
      centerY1   <= START_YS;
      sprite_num <= SPR_DOWN;
      alive      <= 1'b1;
    end else begin
      state      <= state_n;
      move_req   <= req_n;
      candX      <= cx_n;
      candY      <= cy_n;
      centerX1   <= px_n;
      centerY1   <= py_n;
      sprite_num <= spr_n;
      alive      <= alive_n;
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - self-checking bench for player_ctrl
module tb_player_ctrl;

  localparam int DF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0, hit = 1'b0, restart = 1'b0;
  logic move_ack = 1'b0, move_ok = 1'b0;
  logic [3:0] btn = 4'b0000;

  logic a_req, b_req, a_al, b_al;
  logic signed [10:0] a_cx, a_cy, a_x, a_y, b_cx, b_cy, b_x, b_y;
  logic [2:0] a_spr, b_spr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  player_ctrl u_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .hit(hit),
    .restart(restart), .move_req(a_req), .candX(a_cx), .candY(a_cy),
    .move_ack(move_ack), .move_ok(move_ok), .centerX1(a_x), .centerY1(a_y),
    .sprite_num(a_spr), .alive(a_al)
  );

  player_ctrl #(.START_X(767)) u_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .hit(hit),
    .restart(restart), .move_req(b_req), .candX(b_cx), .candY(b_cy),
    .move_ack(move_ack), .move_ok(move_ok), .centerX1(b_x), .centerY1(b_y),
    .sprite_num(b_spr), .alive(b_al)
  );

  // Behavioural model: one record per instance, positions as plain ints.
  int start_x[2] = '{64, 767};
  int mx[2], my[2], mspr[2], mal[2], mreq[2], mcx[2], mcy[2];
  int mdying[2], mdead[2], mticks[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = start_x[i]; my[i] = 64; mcx[i] = start_x[i]; mcy[i] = 64;
      mspr[i] = 0; mal[i] = 1; mreq[i] = 0;
      mdying[i] = 0; mdead[i] = 0; mticks[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int tx, ty;
    if (!mdying[i] && !mdead[i] && hit) begin
      mdying[i] = 1; mticks[i] = 0; mspr[i] = 4; mal[i] = 0; mreq[i] = 0;
    end else if (mdying[i]) begin
      if (frame_tick) begin
        mticks[i]++;
        if (mticks[i] == 3 * DF) begin
          mdying[i] = 0; mdead[i] = 1; mspr[i] = 6;
        end else begin
          mspr[i] = 4 + mticks[i] / DF;
        end
      end
    end else if (mdead[i]) begin
      if (restart) begin
        mx[i] = start_x[i]; my[i] = 64; mspr[i] = 0; mal[i] = 1; mdead[i] = 0;
      end
    end else if (mreq[i]) begin
      if (move_ack) begin
        if (move_ok) begin mx[i] = mcx[i]; my[i] = mcy[i]; end
        mreq[i] = 0;
      end
    end else if (frame_tick && btn != 4'b0000) begin
      tx = mx[i]; ty = my[i];
      if (btn[3])      begin ty = ty - 2; mspr[i] = 1; end
      else if (btn[2]) begin ty = ty + 2; mspr[i] = 0; end
      else if (btn[1]) begin tx = tx - 2; mspr[i] = 2; end
      else             begin tx = tx + 2; mspr[i] = 3; end
      tx = (tx < 0) ? 0 : ((tx > 768) ? 768 : tx);
      ty = (ty < 0) ? 0 : ((ty > 568) ? 568 : ty);
      if (tx != mx[i] || ty != my[i]) begin
        mreq[i] = 1; mcx[i] = tx; mcy[i] = ty;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(input string name, input integer act, input integer exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("a_x", a_x, mx[0]);     chk("b_x", b_x, mx[1]);
    chk("a_y", a_y, my[0]);     chk("b_y", b_y, my[1]);
    chk("a_spr", a_spr, mspr[0]); chk("b_spr", b_spr, mspr[1]);
    chk("a_alive", a_al, mal[0]); chk("b_alive", b_al, mal[1]);
    chk("a_req", a_req, mreq[0]); chk("b_req", b_req, mreq[1]);
    if (mreq[0] != 0) begin chk("a_candX", a_cx, mcx[0]); chk("a_candY", a_cy, mcy[0]); end
    if (mreq[1] != 0) begin chk("b_candX", b_cx, mcx[1]); chk("b_candY", b_cy, mcy[1]); end
  end

  task automatic tick();
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic ack(input logic ok);
    move_ack = 1'b1; move_ok = ok; @(negedge clk); move_ack = 1'b0; move_ok = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_x", a_x, 64);   chk("rst_y", a_y, 64);    chk("rst_spr", a_spr, 0);
    chk("rst_alive", a_al, 1); chk("rst_req", a_req, 0); chk("rst_candX", a_cx, 64);
    chk("rst_bx", b_x, 767);

    // Right move, accepted; B clamps 767 -> 768.
    btn = 4'b0001;
    tick();
    chk("right_req", a_req, 1); chk("right_candX", a_cx, 66); chk("right_spr", a_spr, 3);
    chk("b_candX_768", b_cx, 768);
    @(negedge clk);
    ack(1'b1);
    chk("commit_x", a_x, 66); chk("commit_bx", b_x, 768); chk("commit_req", a_req, 0);

    // B at the right edge: no request, stays at 768.
    tick();
    chk("edge_breq", b_req, 0); chk("edge_areq", a_req, 1);
    ack(1'b1);
    chk("edge_bx", b_x, 768); chk("step2_x", a_x, 68);

    // Up wins over left; extra ticks during CHECK are dropped; rejected.
    btn = 4'b1010;
    tick();
    chk("up_spr", a_spr, 1); chk("up_candY", a_cy, 62);
    tick(); tick();
    ack(1'b0);
    chk("reject_y", a_y, 64); chk("reject_req", a_req, 0);
    repeat (3) @(negedge clk);
    chk("no_queue_req", a_req, 0);

    // Hit in the same cycle as an accepting ack.
    btn = 4'b0001;
    tick();
    btn = 4'b0000;
    hit = 1'b1; move_ack = 1'b1; move_ok = 1'b1;
    @(negedge clk);
    hit = 1'b0; move_ack = 1'b0; move_ok = 1'b0;
    chk("hit_x", a_x, 68); chk("hit_alive", a_al, 0); chk("hit_spr", a_spr, 4); chk("hit_req", a_req, 0);
    for (int k = 1; k <= 3 * DF; k++) begin
      if (k == 3) begin hit = 1'b1; @(negedge clk); hit = 1'b0; end
      if (k == 5) begin restart = 1'b1; @(negedge clk); restart = 1'b0; end
      tick();
      chk("death_spr", a_spr, (k < 8) ? 4 : ((k < 16) ? 5 : 6));
    end
    tick(); tick();
    chk("dead_spr", a_spr, 6); chk("dead_alive", a_al, 0);

    restart = 1'b1; @(negedge clk); restart = 1'b0;
    chk("respawn_x", a_x, 64); chk("respawn_y", a_y, 64);
    chk("respawn_spr", a_spr, 0); chk("respawn_alive", a_al, 1); chk("respawn_bx", b_x, 767);

    // Restart outside DEAD is ignored.
    btn = 4'b0001;
    tick(); ack(1'b1);
    btn = 4'b0000;
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    chk("idle_restart_x", a_x, 66);

    // Hit together with frame_tick: that tick does not count.
    hit = 1'b1; frame_tick = 1'b1; @(negedge clk); hit = 1'b0; frame_tick = 1'b0;
    repeat (DF - 1) tick();
    chk("ht_spr4", a_spr, 4);
    tick();
    chk("ht_spr5", a_spr, 5);
    repeat (2 * DF) tick();
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    chk("ht_respawn", a_al, 1);

    // Reset while requesting, then a stray ack.
    btn = 4'b0001;
    tick();
    chk("pre_rst_req", a_req, 1);
    reset = 1'b1; #1;
    chk("async_req", a_req, 0); chk("async_candX", a_cx, 64); chk("async_x", a_x, 64);
    chk("async_spr", a_spr, 0);
    @(negedge clk);
    reset = 1'b0; btn = 4'b0000;
    ack(1'b1);
    @(negedge clk);
    chk("stray_req", a_req, 0); chk("stray_x", a_x, 64);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
